// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// opcode constants, ALUOp / PCSrc / RegDst codes and the packed control word
// produced by mc_decode.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic       wr_reg_d_src;
    logic [1:0] reg_dst;
    logic       ext_sel;
    logic       m_rd;
    logic       m_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  // Anything outside this set is executed as a NOP.
  function automatic logic op_valid(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLL, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
      OP_J, OP_JR, OP_JAL, OP_HALT: op_valid = 1'b1;
      default:                      op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Purely combinational control decode: (state, op, zero, sign) -> control word.
// Ports: state (current FSM state), op (IR opcode), zero/sign (ALU flags,
// meaningful in EXE), ctrl (every datapath enable and mux select).
// Reset masking and memory-wait gating are applied by the parent.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl              = '0;
    ctrl.reg_dst      = RD_RT;
    ctrl.wr_reg_d_src = 1'b1;
    ctrl.ext_sel      = 1'b1;
    ctrl.alu_op       = ALU_ADD;
    ctrl.pc_src       = PC_NEXT;

    // ALU operand selects are held from EXE through WB so the ALU result
    // stays stable while it is consumed.
    if (state == S_EXE || state == S_MEM || state == S_WB) begin
      case (op)
        OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ctrl.alu_op = ALU_SUB;
        OP_AND:  ctrl.alu_op = ALU_AND;
        OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; end
        OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; end
        OP_XORI: begin ctrl.alu_op = ALU_XOR; ctrl.alu_src_b = 1'b1; ctrl.ext_sel = 1'b0; end
        OP_SLL:  begin ctrl.alu_op = ALU_SLL; ctrl.alu_src_a = 1'b1; end
        OP_SLTI: begin ctrl.alu_op = ALU_SLT; ctrl.alu_src_b = 1'b1; end
        OP_ADDIU, OP_LW, OP_SW: ctrl.alu_src_b = 1'b1;
        default: ;
      endcase
    end

    case (state)
      S_IF: begin
        ctrl.ins_mem_rw = 1'b1;
        ctrl.ir_wre     = 1'b1;
      end
      S_ID: begin
        case (op)
          OP_J:  begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_JUMP; end
          OP_JR: begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_RS; end
          OP_JAL: begin
            ctrl.pc_wre       = 1'b1;
            ctrl.pc_src       = PC_JUMP;
            ctrl.reg_wre      = 1'b1;
            ctrl.reg_dst      = RD_RA;
            ctrl.wr_reg_d_src = 1'b0;
          end
          default: begin
            if (!op_valid(op)) ctrl.pc_wre = 1'b1;
          end
        endcase
      end
      S_EXE: begin
        case (op)
          OP_BEQ:  begin ctrl.pc_wre = 1'b1; if (zero)  ctrl.pc_src = PC_BRANCH; end
          OP_BNE:  begin ctrl.pc_wre = 1'b1; if (!zero) ctrl.pc_src = PC_BRANCH; end
          OP_BLTZ: begin ctrl.pc_wre = 1'b1; if (sign)  ctrl.pc_src = PC_BRANCH; end
          default: ;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          ctrl.m_wr   = 1'b1;
          ctrl.pc_wre = 1'b1;
        end else begin
          ctrl.m_rd = 1'b1;
        end
      end
      S_WB: begin
        ctrl.reg_wre      = 1'b1;
        ctrl.wr_reg_d_src = 1'b1;
        ctrl.pc_wre       = 1'b1;
        ctrl.db_data_src  = (op == OP_LW);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_SLL)
          ctrl.reg_dst = RD_RD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: holds the IF/ID/EXE/MEM/WB/HALT state
// register and next-state logic; control outputs come from mc_decode.
// Ports: clk, Rst (sync, active-high), op, zero, sign, mem_ready inputs;
// PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc,
// RegDst, ExtSel, mRD, mWR, PCSrc, ALUOp control outputs; state (debug).
// Optional macro MC_MEM_WAIT_EN: MEM stalls while mem_ready=0, with the
// memory strobe held and the exit actions deferred to the mem_ready=1 cycle.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_go;

`ifdef MC_MEM_WAIT_EN
  assign mem_go = !(state_q == S_MEM && !mem_ready);
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  mc_decode u_decode (
    .state (state_q),
    .op    (op),
    .zero  (zero),
    .sign  (sign),
    .ctrl  (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op)
          OP_J, OP_JR, OP_JAL: state_d = S_IF;
          OP_HALT:             state_d = S_HALT;
          default:             state_d = op_valid(op) ? S_EXE : S_IF;
        endcase
      end
      S_EXE: begin
        case (op)
          OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_IF;
          OP_LW, OP_SW:            state_d = S_MEM;
          default:                 state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_go) state_d = (op == OP_LW) ? S_WB : S_IF;
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Enables are suppressed during reset; PCWre also waits out a memory stall.
  assign PCWre     = ctrl.pc_wre & mem_go & ~Rst;
  assign IRWre     = ctrl.ir_wre & ~Rst;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign RegWre    = ctrl.reg_wre & ~Rst;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign DBDataSrc = ctrl.db_data_src;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign RegDst    = ctrl.reg_dst;
  assign ExtSel    = ctrl.ext_sel;
  assign mRD       = ctrl.m_rd & ~Rst;
  assign mWR       = ctrl.m_wr & ~Rst;
  assign PCSrc     = ctrl.pc_src;
  assign ALUOp     = ctrl.alu_op;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks instructions through the FSM
// and checks state and control outputs each cycle against hand-derived values.
module tb_multi_cycle_ctrl;

  logic       clk;
  logic       Rst;
  logic [5:0] op;
  logic       zero, sign, mem_ready;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcA, ALUSrcB;
  logic       DBDataSrc, WrRegDSrc, ExtSel, mRD, mWR;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  int vectors;
  int miscompares;

  multi_cycle_ctrl dut (
    .clk       (clk),
    .Rst       (Rst),
    .op        (op),
    .zero      (zero),
    .sign      (sign),
    .mem_ready (mem_ready),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .DBDataSrc (DBDataSrc),
    .WrRegDSrc (WrRegDSrc),
    .RegDst    (RegDst),
    .ExtSel    (ExtSel),
    .mRD       (mRD),
    .mWR       (mWR),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; outputs are observed at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst = 1'b1; op = 6'b000000; zero = 1'b0; sign = 1'b0; mem_ready = 1'b1;

    // reset
    @(negedge clk);
    step();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_pcwre", {7'd0, PCWre}, 8'd0);
    chk("rst_irwre", {7'd0, IRWre}, 8'd0);
    chk("rst_regwre", {7'd0, RegWre}, 8'd0);
    chk("rst_mrd_mwr", {6'd0, mRD, mWR}, 8'd0);

    // add: IF ID EXE WB IF
    Rst = 1'b0; #1;
    chk("add_if_state", {5'd0, state}, 8'd0);
    chk("add_if_ir", {6'd0, IRWre, InsMemRW}, 8'd3);
    chk("add_if_pcwre", {7'd0, PCWre}, 8'd0);
    step();
    chk("add_id_state", {5'd0, state}, 8'd1);
    chk("add_id_en", {5'd0, PCWre, RegWre, IRWre}, 8'd0);
    step();
    chk("add_exe_state", {5'd0, state}, 8'd2);
    chk("add_exe_aluop", {5'd0, ALUOp}, 8'd0);
    chk("add_exe_en", {6'd0, PCWre, RegWre}, 8'd0);
    chk("add_exe_regdst", {6'd0, RegDst}, 8'd1);
    step();
    chk("add_wb_state", {5'd0, state}, 8'd4);
    chk("add_wb_wr", {5'd0, RegWre, WrRegDSrc, DBDataSrc}, 8'b110);
    chk("add_wb_regdst", {6'd0, RegDst}, 8'd2);
    chk("add_wb_pc", {5'd0, PCWre, PCSrc}, 8'b100);
    step();
    chk("add_end_state", {5'd0, state}, 8'd0);

    // lw: IF ID EXE MEM WB IF
    op = 6'b100111;
    step();
    chk("lw_id_state", {5'd0, state}, 8'd1);
    step();
    chk("lw_exe_state", {5'd0, state}, 8'd2);
    chk("lw_exe_sel", {3'd0, ALUOp, ALUSrcB, ExtSel}, 8'b00011);
    step();
    chk("lw_mem_state", {5'd0, state}, 8'd3);
    chk("lw_mem_strb", {5'd0, mRD, mWR, PCWre}, 8'b100);
    step();
    chk("lw_wb_state", {5'd0, state}, 8'd4);
    chk("lw_wb_src", {4'd0, DBDataSrc, RegWre, RegDst}, 8'b1101);
    chk("lw_wb_pcwre", {7'd0, PCWre}, 8'd1);
    step();
    chk("lw_end_state", {5'd0, state}, 8'd0);

    // beq taken
    op = 6'b110000; zero = 1'b1;
    step(); step();
    chk("beq_t_exe", {3'd0, state, ALUOp[1:0]}, 8'b01001);
    chk("beq_t_pc", {5'd0, PCWre, PCSrc}, 8'b101);
    step();
    chk("beq_t_next", {5'd0, state}, 8'd0);

    // beq not taken
    zero = 1'b0;
    step(); step();
    chk("beq_nt_pc", {5'd0, PCWre, PCSrc}, 8'b100);
    step();
    chk("beq_nt_next", {5'd0, state}, 8'd0);

    // bne taken on zero=0
    op = 6'b110001;
    step(); step();
    chk("bne_t_pc", {5'd0, PCWre, PCSrc}, 8'b101);
    step();

    // bltz taken on sign=1
    op = 6'b110010; sign = 1'b1;
    step(); step();
    chk("bltz_t_pc", {5'd0, PCWre, PCSrc}, 8'b101);
    chk("bltz_aluop", {5'd0, ALUOp}, 8'd1);
    step();
    chk("bltz_next", {5'd0, state}, 8'd0);
    sign = 1'b0;

    // jal: done in ID
    op = 6'b111010;
    step();
    chk("jal_id_state", {5'd0, state}, 8'd1);
    chk("jal_id_wr", {3'd0, RegWre, RegDst, WrRegDSrc, PCWre}, 8'b10001);
    chk("jal_id_pcsrc", {6'd0, PCSrc}, 8'd3);
    step();
    chk("jal_next", {5'd0, state}, 8'd0);

    // jr
    op = 6'b111001;
    step();
    chk("jr_id_pc", {5'd0, PCWre, PCSrc}, 8'b110);
    step();
    chk("jr_next", {5'd0, state}, 8'd0);

    // undefined opcode -> NOP
    op = 6'b000111;
    step();
    chk("nop_id_pc", {4'd0, PCWre, RegWre, PCSrc}, 8'b1000);
    step();
    chk("nop_next", {5'd0, state}, 8'd0);

    // andi: zero-extend, imm operand, rt destination
    op = 6'b010001;
    step(); step();
    chk("andi_exe", {2'd0, ALUOp, ALUSrcA, ALUSrcB, ExtSel}, 8'b100010);
    step();
    chk("andi_wb", {5'd0, state}, 8'd4);
    chk("andi_wb_regdst", {6'd0, RegDst}, 8'd1);
    chk("andi_wb_hold", {3'd0, ALUOp, ExtSel, ALUSrcB}, 8'b10001);
    step();

    // sll: shift amount operand, rd destination
    op = 6'b011000;
    step(); step();
    chk("sll_exe", {4'd0, ALUOp, ALUSrcA}, 8'b0101);
    step();
    chk("sll_wb_regdst", {6'd0, RegDst}, 8'd2);
    step();

    // halt: holds for 10 cycles with enables low
    op = 6'b111111;
    step();
    chk("halt_id", {4'd0, state[1:0], PCWre, RegWre}, 8'b0100);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_state", {5'd0, state}, 8'd7);
      chk("halt_en", {3'd0, PCWre, IRWre, RegWre, mRD, mWR}, 8'd0);
    end
    Rst = 1'b1;
    step();
    chk("halt_rst", {5'd0, state}, 8'd0);
    Rst = 1'b0;

    // sw interrupted by reset in MEM
    op = 6'b100110;
    step(); step(); step();
    chk("sw_mem_state", {5'd0, state}, 8'd3);
    chk("sw_mem_wr", {6'd0, mWR, PCWre}, 8'b11);
    Rst = 1'b1; #1;
    chk("sw_rst_mwr", {6'd0, mWR, PCWre}, 8'd0);
    step();
    chk("sw_rst_next", {5'd0, state}, 8'd0);
    Rst = 1'b0;

`ifdef MC_MEM_WAIT_EN
    // sw with 3 stall cycles in MEM
    step(); step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_state", {5'd0, state}, 8'd3);
      chk("wait_strb", {6'd0, mWR, PCWre}, 8'b10);
    end
    mem_ready = 1'b1; #1;
    chk("wait_exit", {5'd0, state[1:0], mWR, PCWre}, 8'b1111);
    step();
    chk("wait_next", {5'd0, state}, 8'd0);
`else
    // without the wait feature, mem_ready is ignored
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("nowait_mem", {5'd0, state[1:0], mWR, PCWre}, 8'b1111);
    step();
    chk("nowait_next", {5'd0, state}, 8'd0);
    mem_ready = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
